// File: rtl/load_store_unit_pkg.sv
// Shared funct3 codes, FSM state encodings and request-decode helpers for the load/store unit.
package load_store_unit_pkg;

  localparam int WORD_SIZE = 32;

  localparam logic [2:0] LSU_F3_B  = 3'b000;
  localparam logic [2:0] LSU_F3_H  = 3'b001;
  localparam logic [2:0] LSU_F3_W  = 3'b010;
  localparam logic [2:0] LSU_F3_BU = 3'b100;
  localparam logic [2:0] LSU_F3_HU = 3'b101;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_STORE  = 3'd2;
  localparam logic [2:0] ST_RMW_RD = 3'd3;
  localparam logic [2:0] ST_RMW_WR = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // Illegal codes (011, 11x, unsigned stores) collapse to a word access.
  function automatic logic [2:0] lsu_norm_f3(input logic we, input logic [2:0] f3);
    logic [2:0] r;
    case (f3)
      LSU_F3_B, LSU_F3_H:   r = f3;
      LSU_F3_BU, LSU_F3_HU: r = we ? LSU_F3_W : f3;
      default:              r = LSU_F3_W;
    endcase
    return r;
  endfunction

  function automatic logic lsu_is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic r;
    case (f3)
      LSU_F3_H, LSU_F3_HU: r = lo[0];
      LSU_F3_W:            r = (lo != 2'b00);
      default:             r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] lsu_align_lo(input logic [2:0] f3, input logic [1:0] lo);
    logic [1:0] r;
    case (f3)
      LSU_F3_H, LSU_F3_HU: r = {lo[1], 1'b0};
      LSU_F3_W:            r = 2'b00;
      default:             r = lo;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module lsu_align
  import load_store_unit_pkg::*;
#(
  parameter int DATA_W = WORD_SIZE
) (
  input  logic [DATA_W-1:0] rd_word,
  input  logic [DATA_W-1:0] cap_word,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        addr_lo,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] load_ext,
  output logic [DATA_W-1:0] merged
);

  localparam int LANES = DATA_W / 8;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rd_word[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    case (funct3)
      LSU_F3_B:  load_ext = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LSU_F3_BU: load_ext = {{(DATA_W-8){1'b0}}, byte_sel};
      LSU_F3_H:  load_ext = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LSU_F3_HU: load_ext = {{(DATA_W-16){1'b0}}, half_sel};
      default:   load_ext = rd_word;
    endcase
  end

  // Each lane either keeps the captured byte or takes the matching store byte.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic       hit;
      logic [7:0] src;
      assign hit = ((funct3 == LSU_F3_B) && (addr_lo == 2'(gi))) ||
                   ((funct3 == LSU_F3_H) && (addr_lo[1] == 1'(gi / 2))) ||
                   (funct3 == LSU_F3_W);
      assign src = (funct3 == LSU_F3_B) ? wdata[7:0] :
                   (funct3 == LSU_F3_H) ? wdata[8*(gi%2) +: 8] : wdata[8*gi +: 8];
      assign merged[8*gi +: 8] = hit ? src : cap_word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Load/store FSM between execute and a word-wide data memory.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned H/W instead of aligning them).
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DATA_W = WORD_SIZE,
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_we,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rdata,
  output logic [ADDR_W-1:0] o_dm_addr,
  output logic [DATA_W-1:0] o_dm_wd,
  output logic              o_dm_wen,
  output logic              o_dm_ren,
  input  logic [DATA_W-1:0] i_dm_rd
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic              o_misaligned
`endif
);

  logic [2:0]        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [2:0]        f3_reg;
  logic [DATA_W-1:0] wdata_reg, merge_reg, rdata_reg;
  logic              accept, req_mis, dm_active;
  logic [2:0]        req_f3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] load_ext, merged;

  assign accept = i_valid & o_ready;
  assign req_f3 = lsu_norm_f3(i_we, i_funct3);

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_reg;
  assign req_addr     = i_addr;
  assign req_mis      = lsu_is_misaligned(req_f3, i_addr[1:0]);
  assign o_misaligned = (state_reg == ST_DONE) & mis_reg;
`else
  assign req_addr = {i_addr[ADDR_W-1:2], lsu_align_lo(req_f3, i_addr[1:0])};
  assign req_mis  = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (req_mis)                 state_next = ST_DONE;
          else if (!i_we)              state_next = ST_LOAD;
          else if (req_f3 == LSU_F3_W) state_next = ST_STORE;
          else                         state_next = ST_RMW_RD;
        end
      end
      ST_LOAD, ST_STORE, ST_RMW_WR: state_next = ST_DONE;
      ST_RMW_RD:                    state_next = ST_RMW_WR;
      default:                      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      f3_reg    <= LSU_F3_B;
      wdata_reg <= '0;
      merge_reg <= '0;
      rdata_reg <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg  <= req_addr;
        f3_reg    <= req_f3;
        wdata_reg <= i_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_reg   <= req_mis;
`endif
      end
      if (state_reg == ST_LOAD)   rdata_reg <= load_ext;
      if (state_reg == ST_RMW_RD) merge_reg <= i_dm_rd;
    end
  end

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .rd_word  (i_dm_rd),
    .cap_word (merge_reg),
    .wdata    (wdata_reg),
    .addr_lo  (addr_reg[1:0]),
    .funct3   (f3_reg),
    .load_ext (load_ext),
    .merged   (merged)
  );

  // Memory-side outputs are decoded from state so IDLE/DONE stay quiet.
  assign o_ready   = (state_reg == ST_IDLE);
  assign o_done    = (state_reg == ST_DONE);
  assign o_rdata   = rdata_reg;
  assign o_dm_ren  = (state_reg == ST_LOAD) || (state_reg == ST_RMW_RD);
  assign o_dm_wen  = (state_reg == ST_STORE) || (state_reg == ST_RMW_WR);
  assign dm_active = o_dm_ren | o_dm_wen;
  assign o_dm_addr = dm_active ? {addr_reg[ADDR_W-1:2], 2'b00} : '0;
  assign o_dm_wd   = (state_reg == ST_STORE)  ? wdata_reg :
                     (state_reg == ST_RMW_WR) ? merged    : '0;

endmodule
